pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised successor to the 4-bit ripple adder: a WIDTH-bit adder/subtractor whose carry chain is split into STAGES registered slices.
- Each pipeline stage resolves WIDTH/STAGES sum bits.
- Valid/ready handshake on input and output; signed-overflow, carry and zero flags.
- Sits between operand sources (register file, counters) and ALU result muxing, where the combinational ripple path no longer meets timing at larger widths.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- STAGES, 2, number of pipeline stages; WIDTH % STAGES == 0 is required (elaboration error otherwise). STAGES=1 gives a single registered ripple adder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- op_sub  input  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst=0, async): clear all stage valid bits and all data/carry registers. Outputs go to out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 once rst=1.
- Reset mid-operation discards all in-flight beats with no partial result. The first post-reset acceptance occurs on the first rising edge with rst=1.
- Subtract mapping: operand B becomes ~b and carry-in becomes ~cin, so the result is A−B−cin. cout is the raw carry of the final slice.
- Slice k (k=0..STAGES−1) covers bits [k·W/S +: W/S].
  - Stage k adds slice k of the skewed operands plus the carry registered from stage k−1. Stage 0 uses the mapped cin.
  - Higher slices of A and the mapped B are carried forward in pipeline registers. Lower result bits are carried forward alongside.
- ovf = (a[MSB] == bmapped[MSB]) && (sum[MSB] != a[MSB]). Computed in the final stage from the forwarded MSBs.
- zero is computed from the full registered sum in the final stage.
- Latency: a beat accepted at edge t gives out_valid=1 after edge t+STAGES−1. With STAGES=1 the result appears the cycle after acceptance.
- Handshake:
  - advance = !out_valid || out_ready. in_ready = advance (combinational). Accept when in_valid && in_ready.
  - When advance=0 every stage holds, including bubbles; no beat is lost or duplicated.
  - When advance=1 every stage shifts. The stage-0 valid loads in_valid.
  - out_valid/sum/flags stay stable while out_valid && !out_ready.
  - Throughput is 1 beat/cycle with out_ready held at 1.
- in_valid=0 inserts a bubble. Bubbles propagate, and output fields are don't-care while out_valid=0.
- Wrap-around: sum wraps modulo 2^WIDTH and the carry goes to cout.
- Simultaneous events: output consumed and new input accepted in the same cycle is allowed (advance=1).

Test Plan:
- WIDTH=8, STAGES=2, add a=0x3C, b=0x0F, cin=0, out_ready=1 -> after 2 edges sum=0x4B, cout=0, ovf=0, zero=0.
- Add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, zero=1, ovf=0. Add 0x7F+0x01 -> sum=0x80, ovf=1, cout=0.
- Sub 0x05−0x07, cin=0 -> sum=0xFE, cout=0 (borrow). Sub 0x80−0x01 -> sum=0x7F, ovf=1, cout=1. Sub 0x10−0x0F, cin=1 -> sum=0x00, zero=1.
- Back-to-back stream of 8 beats (k, 2k) with out_ready=1 -> 8 consecutive out_valid cycles with sum=3k in order. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and output stable; after release, no beat is lost or repeated.
- Random in_valid bubbles with random out_ready over 1000 beats -> the output sequence matches a reference model of (a±b±cin) and its flags, in order.
- Assert rst=0 with 2 beats in flight -> out_valid=0 and all outputs 0 immediately (async). After release, a new beat 0x01+0x01 yields sum=0x02 after 2 edges.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor with the carry chain cut into
// STAGES registered slices. Each stage resolves WIDTH/STAGES sum bits, takes
// the carry registered by the previous stage, and forwards the still-pending
// operand bits together with the already-resolved low result bits.
// A single global advance signal moves or holds every stage (valid/ready).
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW  = WIDTH / STAGES;   // bits resolved per stage
    localparam int MSB = WIDTH - 1;

    // Refuse to elaborate with a slicing that does not divide the word evenly.
    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES");
        end
    endgenerate

    // Per-stage pipeline registers. a/bm keep the operand bits that higher
    // stages still need; sum holds the result bits resolved so far.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bm_q    [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bm_d    [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             valid_d [STAGES];
    logic             ovf_d;

    logic             advance;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] bm_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [SW:0]      slice_res;
    int               prev;

    // Next-state for every stage: add one slice when advancing, else hold all.
    always_comb begin
        advance   = !valid_q[STAGES-1] || out_ready;
        a_src     = '0;
        bm_src    = '0;
        s_src     = '0;
        c_src     = 1'b0;
        v_src     = 1'b0;
        slice_res = '0;
        prev      = 0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]     = a_q[k];
            bm_d[k]    = bm_q[k];
            sum_d[k]   = sum_q[k];
            carry_d[k] = carry_q[k];
            valid_d[k] = valid_q[k];
        end
        ovf_d = ovf_q;

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction is A + ~B + ~cin, so a borrow-in maps to no carry-in.
                a_src  = a;
                bm_src = op_sub ? ~b : b;
                c_src  = cin ^ op_sub;
                s_src  = '0;
                v_src  = in_valid;
            end else begin
                prev   = k - 1;
                a_src  = a_q[prev];
                bm_src = bm_q[prev];
                c_src  = carry_q[prev];
                s_src  = sum_q[prev];
                v_src  = valid_q[prev];
            end
            slice_res = {1'b0, a_src[k*SW +: SW]} + {1'b0, bm_src[k*SW +: SW]}
                      + {{SW{1'b0}}, c_src};
            if (advance) begin
                a_d[k]              = a_src;
                bm_d[k]             = bm_src;
                sum_d[k]            = s_src;
                sum_d[k][k*SW +: SW] = slice_res[SW-1:0];
                carry_d[k]          = slice_res[SW];
                valid_d[k]          = v_src;
            end
        end

        // After the loop the *_src values belong to the final stage, whose
        // slice contains the MSB: same-sign operands giving a different-sign
        // result is a signed overflow.
        if (advance) begin
            ovf_d = (a_src[MSB] == bm_src[MSB]) && (slice_res[SW-1] != a_src[MSB]);
        end
    end

    // Stage registers; reset drops every in-flight beat and clears all data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                bm_q[k]    <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                bm_q[k]    <= bm_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;
    // Gated by valid so the cleared (all-zero) reset state does not flag zero.
    assign zero      = valid_q[STAGES-1] && (sum_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub (WIDTH=8, STAGES=2): directed cases with
// constant expectations, latency and stall checks, a randomized stream with
// bubbles and back-pressure against an arithmetic reference model, and an
// asynchronous reset with beats in flight.
module tb_pipelined_addsub;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp = '0;
    exp_t held    = '0;
    exp_t popped  = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit rand_or  = 1'b0;
    bit stalled_prev = 1'b0;
    int run_len  = 0;
    int max_run  = 0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_in),
        .b        (b_in),
        .cin      (cin),
        .op_sub   (op_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t   r;
        longint full, sx, sy, cc, sres;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        cc = longint'(c);
        if (!s) begin
            full = longint'(x) + longint'(y) + cc;
            r.c  = (full >= (longint'(1) << W));
            sres = sx + sy + cc;
        end else begin
            full = longint'(x) - longint'(y) - cc;
            r.c  = (full >= 0);
            sres = sx - sy - cc;
        end
        r.s = full[W-1:0];
        r.v = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
        r.z = (r.s == '0);
        return r;
    endfunction

    // Present one beat and hold it until the DUT accepts it.
    task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic ts, input exp_t te);
        bit acc;
        int waited;
        in_valid = 1'b1;
        a_in     = ta;
        b_in     = tb;
        cin      = tc;
        op_sub   = ts;
        cur_exp  = te;
        acc      = 1'b0;
        waited   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 200) begin
                check_eq("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: consume results in order, check stall stability, record accepts.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (stalled_prev) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_sum", 32'(sum), 32'(held.s));
                check_eq("hold_flags", 32'({cout, ovf, zero}), 32'({held.c, held.v, held.z}));
            end
            if (out_valid && out_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    check_eq("sum", 32'(sum), 32'(popped.s));
                    check_eq("cout", 32'(cout), 32'(popped.c));
                    check_eq("ovf", 32'(ovf), 32'(popped.v));
                    check_eq("zero", 32'(zero), 32'(popped.z));
                end
            end else begin
                run_len = 0;
            end
            if (out_valid && !out_ready) check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            stalled_prev = out_valid && !out_ready;
            held = '{s: sum, c: cout, v: ovf, z: zero};
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end else begin
            stalled_prev = 1'b0;
            run_len = 0;
        end
    end

    // Random back-pressure while enabled.
    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] da [5] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10};
    logic [W-1:0] db [5] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h0F};
    logic         dc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic         ds [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t         de [5] = '{'{8'h00, 1'b1, 1'b0, 1'b1},
                             '{8'h80, 1'b0, 1'b1, 1'b0},
                             '{8'hFE, 1'b0, 1'b0, 1'b0},
                             '{8'h7F, 1'b1, 1'b1, 1'b0},
                             '{8'h00, 1'b1, 1'b0, 1'b1}};

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // First beat with explicit latency check
        drive_beat(8'h3C, 8'h0F, 1'b0, 1'b0, '{8'h4B, 1'b0, 1'b0, 1'b0});
        check_eq("lat_edge1_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("lat_edge2_valid", 32'(out_valid), 32'd1);
        check_eq("lat_edge2_sum", 32'(sum), 32'h4B);

        // Directed corner cases
        for (int i = 0; i < 5; i++) drive_beat(da[i], db[i], dc[i], ds[i], de[i]);
        in_valid = 1'b0;
        wait_drain();

        // Back-to-back stream of (k, 2k)
        max_run = 0;
        for (int k = 1; k <= 8; k++) begin
            ra = W'(k);
            rb = W'(2 * k);
            drive_beat(ra, rb, 1'b0, 1'b0, '{W'(3 * k), 1'b0, 1'b0, 1'b0});
        end
        in_valid = 1'b0;
        wait_drain();
        check_eq("stream_run", 32'(max_run), 32'd8);

        // Stream with a 3-cycle output stall in the middle
        for (int k = 1; k <= 4; k++) begin
            ra = W'(k + 16);
            rb = W'(k * 5);
            drive_beat(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        out_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        for (int k = 5; k <= 8; k++) begin
            ra = W'(k + 16);
            rb = W'(k * 5);
            drive_beat(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        wait_drain();

        // Randomized stream with bubbles and back-pressure
        rand_or = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            drive_beat(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        in_valid = 1'b0;
        rand_or  = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with two beats in flight
        drive_beat(8'h20, 8'h30, 1'b0, 1'b0, model(8'h20, 8'h30, 1'b0, 1'b0));
        drive_beat(8'h44, 8'h11, 1'b1, 1'b1, model(8'h44, 8'h11, 1'b1, 1'b1));
        in_valid = 1'b0;
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_sum", 32'(sum), 32'd0);
        check_eq("async_rst_cout", 32'(cout), 32'd0);
        check_eq("async_rst_ovf", 32'(ovf), 32'd0);
        check_eq("async_rst_zero", 32'(zero), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        drive_beat(8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 1'b0, 1'b0, 1'b0});
        check_eq("post_rst_edge1_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_edge2_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_edge2_sum", 32'(sum), 32'h02);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
